// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU RAM master: op encoding, FSM states,
// captured request payload and RAM read-latency bounds.
package lsu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_W      = 5;
    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;
    localparam int unsigned CNT_W      = 2;

    typedef enum logic [2:0] {
        LD_B  = 3'd0,
        LD_H  = 3'd1,
        LD_W  = 3'd2,
        LD_BU = 3'd3,
        LD_HU = 3'd4,
        ST_B  = 3'd5,
        ST_H  = 3'd6,
        ST_W  = 3'd7
    } lsu_op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_t;

    typedef struct packed {
        lsu_op_t               op;
        logic [XLEN-1:0]       addr;
        logic [XLEN-1:0]       wdata;
        logic [REG_W-1:0]      rd;
    } lsu_req_t;

    function automatic logic is_load(lsu_op_t op);
        return (op inside {LD_B, LD_H, LD_W, LD_BU, LD_HU});
    endfunction

    // Halfword ops need an even address, word ops a multiple of four.
    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
        logic mis;
        case (op)
            LD_H, LD_HU, ST_H: mis = off[0];
            LD_W, ST_W:        mis = (off != 2'b00);
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extends a loaded byte/half from a RAM word and
// merges sub-word store data into a RAM word.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_c_o,
    output logic [31:0] st_word_c_o
);

    lsu_op_t     op;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op = lsu_op_t'(op_i);

    always_comb begin
        byte_sel    = word_i[{off_i, 3'b000} +: 8];
        half_sel    = off_i[1] ? word_i[31:16] : word_i[15:0];
        ld_data_c_o = word_i;
        case (op)
            LD_B:    ld_data_c_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ld_data_c_o = {24'h0, byte_sel};
            LD_H:    ld_data_c_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ld_data_c_o = {16'h0, half_sel};
            default: ld_data_c_o = word_i;
        endcase
    end

    // Read-modify-write: only the addressed lane takes store data.
    always_comb begin
        st_word_c_o = wdata_i;
        case (op)
            ST_B: begin
                st_word_c_o = word_i;
                st_word_c_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            ST_H: begin
                st_word_c_o = word_i;
                if (off_i[1]) st_word_c_o[31:16] = wdata_i[15:0];
                else          st_word_c_o[15:0]  = wdata_i[15:0];
            end
            default: st_word_c_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store unit master for a fixed-latency word RAM: aligned loads with
// extension, sub-word stores by read-modify-write, misalignment responses.
module lsu_ram_master
    import lsu_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rd_valid,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        wr_valid,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        resp_valid,
    output logic        resp_ale,
    output logic        rf_en,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data
);

    // Out-of-range latencies are clamped to the supported window.
    localparam int unsigned LAT = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                                  (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;

    lsu_state_t       state_q, state_d;
    lsu_req_t         req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req_ready_q, req_ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic        wr_valid_q, wr_valid_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_ale_q, resp_ale_d;
    logic        rf_en_q, rf_en_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_data_q, rf_data_d;

    logic [31:0] ld_data_c;
    logic [31:0] st_word_c;

    lsu_byte_lane u_lane (
        .op_i        (req_d.op),
        .off_i       (req_d.addr[1:0]),
        .word_i      (rd_data),
        .wdata_i     (req_d.wdata),
        .ld_data_c_o (ld_data_c),
        .st_word_c_o (st_word_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            req_q        <= '0;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_ale_q   <= 1'b0;
            rf_en_q      <= 1'b0;
            rf_addr_q    <= '0;
            rf_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_addr_q    <= rd_addr_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            resp_valid_q <= resp_valid_d;
            resp_ale_q   <= resp_ale_d;
            rf_en_q      <= rf_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_data_q    <= rf_data_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.op    = lsu_op_t'(req_op);
                    req_d.addr  = req_addr;
                    req_d.wdata = req_wdata;
                    req_d.rd    = req_rd;
                    if (is_misaligned(lsu_op_t'(req_op), req_addr[1:0])) state_d = RESP;
                    else if (lsu_op_t'(req_op) == ST_W)                  state_d = WRITE;
                    else                                                  state_d = READ;
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(LAT - 1);
            end
            WAIT: begin
                if (cnt_q == '0) state_d = is_load(req_q.op) ? RESP : WRITE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        req_ready_d  = (state_d == IDLE);
        rd_valid_d   = (state_d == READ);
        rd_addr_d    = rd_valid_d ? {req_d.addr[31:2], 2'b00} : 32'h0;
        wr_valid_d   = (state_d == WRITE);
        wr_addr_d    = wr_valid_d ? {req_d.addr[31:2], 2'b00} : 32'h0;
        wr_data_d    = wr_valid_d ? st_word_c : 32'h0;
        resp_valid_d = (state_d == RESP);
        resp_ale_d   = resp_valid_d && is_misaligned(req_d.op, req_d.addr[1:0]);
        rf_en_d      = resp_valid_d && !resp_ale_d && is_load(req_d.op) && (req_d.rd != '0);
        rf_addr_d    = rf_en_d ? req_d.rd : 5'h0;
        rf_data_d    = rf_en_d ? ld_data_c : 32'h0;
    end

    assign req_ready  = req_ready_q;
    assign rd_valid   = rd_valid_q;
    assign rd_addr    = rd_addr_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_ale   = resp_ale_q;
    assign rf_en      = rf_en_q;
    assign rf_addr    = rf_addr_q;
    assign rf_data    = rf_data_q;

endmodule

// File: tb/tb_lsu_ram_master.sv
// Directed bench for lsu_ram_master: one instance at read latency 1, one at 3,
// each fed by a small delayed-read RAM model.
module tb_lsu_ram_master;
    import lsu_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid [2];
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        req_ready [2];
    logic        rd_valid [2];
    logic [31:0] rd_addr [2];
    logic [31:0] rd_data [2];
    logic        wr_valid [2];
    logic [31:0] wr_addr [2];
    logic [31:0] wr_data [2];
    logic        resp_valid [2];
    logic        resp_ale [2];
    logic        rf_en [2];
    logic [4:0]  rf_addr [2];
    logic [31:0] rf_data [2];

    logic [31:0] ram_word;
    logic [3:0]  vpipe [2];
    int          n_vec;
    int          n_err;

    typedef struct {
        int          sel;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] ram;
        int          x_rd_cyc;
        logic [31:0] x_rd_addr;
        int          x_wr_cyc;
        logic [31:0] x_wr_addr;
        logic [31:0] x_wr_data;
        int          x_resp_cyc;
        logic        x_ale;
        logic        x_rf_en;
        logic [31:0] x_rf_data;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lsu_ram_master #(.RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rd_valid(rd_valid[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .wr_valid(wr_valid[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
        .resp_valid(resp_valid[0]), .resp_ale(resp_ale[0]),
        .rf_en(rf_en[0]), .rf_addr(rf_addr[0]), .rf_data(rf_data[0])
    );

    lsu_ram_master #(.RD_LATENCY(3)) u_dut_l3 (
        .clk(clk), .rstn(rstn), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rd_valid(rd_valid[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .wr_valid(wr_valid[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
        .resp_valid(resp_valid[1]), .resp_ale(resp_ale[1]),
        .rf_en(rf_en[1]), .rf_addr(rf_addr[1]), .rf_data(rf_data[1])
    );

    // RAM model: data is valid only in the cycle RD_LATENCY after the strobe, garbage otherwise.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vpipe[0] <= '0;
            vpipe[1] <= '0;
        end else begin
            vpipe[0] <= {vpipe[0][2:0], rd_valid[0]};
            vpipe[1] <= {vpipe[1][2:0], rd_valid[1]};
        end
    end
    assign rd_data[0] = vpipe[0][0] ? ram_word : 32'hDEAD_BEEF;
    assign rd_data[1] = vpipe[1][2] ? ram_word : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int s);
        chk({tag, " req_ready"},  32'(req_ready[s]),  32'd1);
        chk({tag, " rd_valid"},   32'(rd_valid[s]),   32'd0);
        chk({tag, " rd_addr"},    rd_addr[s],         32'd0);
        chk({tag, " wr_valid"},   32'(wr_valid[s]),   32'd0);
        chk({tag, " wr_addr"},    wr_addr[s],         32'd0);
        chk({tag, " wr_data"},    wr_data[s],         32'd0);
        chk({tag, " resp_valid"}, 32'(resp_valid[s]), 32'd0);
        chk({tag, " resp_ale"},   32'(resp_ale[s]),   32'd0);
        chk({tag, " rf_en"},      32'(rf_en[s]),      32'd0);
        chk({tag, " rf_addr"},    32'(rf_addr[s]),    32'd0);
        chk({tag, " rf_data"},    rf_data[s],         32'd0);
    endtask

    // Called at a falling edge; applies one request and watches ten cycles after acceptance.
    task automatic run_vec(input string tag, input vec_t v);
        int s = v.sel;
        int rd_n = 0, rd_at = 0, wr_n = 0, wr_at = 0, rs_n = 0, rs_at = 0;
        logic [31:0] rd_a = '0, wr_a = '0, wr_d = '0, rf_d = '0;
        logic [4:0]  rf_a = '0;
        logic ale = 1'b0, rfe = 1'b0, zbad = 1'b0, rdy_bad = 1'b0;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_rd    = v.rd;
        ram_word  = v.ram;
        req_valid[s] = 1'b1;
        #1;
        chk({tag, " ready_at_accept"}, 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid[s] = 1'b0;
            if (rd_valid[s]) begin rd_n++; rd_at = c; rd_a = rd_addr[s]; end
            else if (rd_addr[s] != 0) zbad = 1'b1;
            if (wr_valid[s]) begin wr_n++; wr_at = c; wr_a = wr_addr[s]; wr_d = wr_data[s]; end
            else if (wr_addr[s] != 0 || wr_data[s] != 0) zbad = 1'b1;
            if (resp_valid[s]) begin
                rs_n++; rs_at = c; ale = resp_ale[s]; rfe = rf_en[s]; rf_a = rf_addr[s]; rf_d = rf_data[s];
            end else if (resp_ale[s] || rf_en[s]) zbad = 1'b1;
            if (!rf_en[s] && (rf_addr[s] != 0 || rf_data[s] != 0)) zbad = 1'b1;
            if (c <= v.x_resp_cyc && req_ready[s]) rdy_bad = 1'b1;
        end
        chk({tag, " rd_count"}, 32'(rd_n), 32'(v.x_rd_cyc != 0));
        if (v.x_rd_cyc != 0) begin
            chk({tag, " rd_cycle"}, 32'(rd_at), 32'(v.x_rd_cyc));
            chk({tag, " rd_addr"},  rd_a, v.x_rd_addr);
        end
        chk({tag, " wr_count"}, 32'(wr_n), 32'(v.x_wr_cyc != 0));
        if (v.x_wr_cyc != 0) begin
            chk({tag, " wr_cycle"}, 32'(wr_at), 32'(v.x_wr_cyc));
            chk({tag, " wr_addr"},  wr_a, v.x_wr_addr);
            chk({tag, " wr_data"},  wr_d, v.x_wr_data);
        end
        chk({tag, " resp_count"}, 32'(rs_n), 32'd1);
        chk({tag, " resp_cycle"}, 32'(rs_at), 32'(v.x_resp_cyc));
        chk({tag, " resp_ale"},   32'(ale), 32'(v.x_ale));
        chk({tag, " rf_en"},      32'(rfe), 32'(v.x_rf_en));
        if (v.x_rf_en) begin
            chk({tag, " rf_addr"}, 32'(rf_a), 32'(v.rd));
            chk({tag, " rf_data"}, rf_d, v.x_rf_data);
        end
        chk({tag, " zero_without_strobe"}, 32'(zbad), 32'd0);
        chk({tag, " ready_low_while_busy"}, 32'(rdy_bad), 32'd0);
        chk({tag, " ready_after_resp"}, 32'(req_ready[s]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r1, r2, rs1, rs2;
        logic rfe1, rfe2, busy, wr_seen;
        logic [4:0]  rfa2;
        logic [31:0] rfd2, rd2a;
        vec_t v;

        //         sel op     addr          wdata         rd    ram           rdc rd_addr       wrc wr_addr       wr_data       rsp ale rfe rf_data
        vecs[0]  = '{0, LD_B,  32'h0000_0103, 32'h0,        5'd5,  32'h80FF_1234, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        3, 0, 1, 32'hFFFF_FF80};
        vecs[1]  = '{0, ST_H,  32'h0000_0202, 32'h0000_ABCD, 5'd7, 32'h1122_3344, 1, 32'h0000_0200, 3, 32'h0000_0200, 32'hABCD_3344, 4, 0, 0, 32'h0};
        vecs[2]  = '{0, LD_W,  32'h0000_0105, 32'h0,        5'd4,  32'h1234_5678, 0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
        vecs[3]  = '{1, LD_HU, 32'h0000_0002, 32'h0,        5'd3,  32'h8001_0000, 1, 32'h0000_0000, 0, 32'h0,        32'h0,        5, 0, 1, 32'h0000_8001};
        vecs[4]  = '{0, LD_H,  32'h0000_0102, 32'h0,        5'd9,  32'h8001_1234, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        3, 0, 1, 32'hFFFF_8001};
        vecs[5]  = '{0, LD_BU, 32'h0000_0101, 32'h0,        5'd1,  32'h1234_F6AB, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        3, 0, 1, 32'h0000_00F6};
        vecs[6]  = '{0, LD_W,  32'h0000_0044, 32'h0,        5'd31, 32'hCAFE_BABE, 1, 32'h0000_0044, 0, 32'h0,        32'h0,        3, 0, 1, 32'hCAFE_BABE};
        vecs[7]  = '{0, ST_W,  32'h0000_0048, 32'h1234_5678, 5'd0, 32'h0,        0, 32'h0,        1, 32'h0000_0048, 32'h1234_5678, 2, 0, 0, 32'h0};
        vecs[8]  = '{0, ST_B,  32'h0000_0301, 32'hFFFF_FF5A, 5'd2, 32'h1122_3344, 1, 32'h0000_0300, 3, 32'h0000_0300, 32'h1122_5A44, 4, 0, 0, 32'h0};
        vecs[9]  = '{0, ST_H,  32'h0000_0101, 32'h0000_1111, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
        vecs[10] = '{0, ST_W,  32'h0000_0102, 32'h0000_2222, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 0, 32'h0};
        vecs[11] = '{0, LD_H,  32'h0000_0100, 32'h0,        5'd2,  32'h1122_7FFF, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        3, 0, 1, 32'h0000_7FFF};
        vecs[12] = '{1, ST_B,  32'h0000_0003, 32'h0000_00AB, 5'd0, 32'h1122_3344, 1, 32'h0000_0000, 5, 32'h0000_0000, 32'hAB22_3344, 6, 0, 0, 32'h0};
        vecs[13] = '{0, LD_B,  32'h0000_0100, 32'h0,        5'd0,  32'h1122_3344, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        3, 0, 0, 32'h0};
        vecs[14] = '{1, LD_B,  32'h0000_0100, 32'h0,        5'd4,  32'h0000_00FF, 1, 32'h0000_0100, 0, 32'h0,        32'h0,        5, 0, 1, 32'hFFFF_FFFF};

        n_vec = 0;
        n_err = 0;
        rstn = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
        ram_word = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset_l1", 0);
        chk_idle("reset_l3", 1);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset while a sub-word store waits for read data: the write must never issue.
        req_op = ST_B; req_addr = 32'h0000_0010; req_wdata = 32'h0000_00EE; req_rd = '0;
        ram_word = 32'h1122_3344;
        req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk_idle("midop_reset", 1);
        wr_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wr_valid[1]) wr_seen = 1'b1;
        end
        chk("midop_reset no_write", 32'(wr_seen), 32'd0);
        rstn = 1'b1;
        v = '{1, ST_W, 32'h0000_0020, 32'h0BAD_F00D, 5'd0, 32'h0, 0, 32'h0, 1, 32'h0000_0020, 32'h0BAD_F00D, 2, 0, 0, 32'h0};
        run_vec("post_reset_stw", v);

        // req_valid held high: second load accepted only once the first has responded.
        r1 = 0; r2 = 0; rs1 = 0; rs2 = 0; rfe1 = 1'b0; rfe2 = 1'b0; busy = 1'b0;
        rfa2 = '0; rfd2 = '0; rd2a = '0;
        ram_word = 32'h5A5A_5A5A;
        req_op = LD_W; req_addr = 32'h0000_0040; req_rd = 5'd0;
        req_valid[0] = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin req_addr = 32'h0000_0080; req_rd = 5'd6; end
            if (c == 5) req_valid[0] = 1'b0;
            if (rd_valid[0]) begin
                if (r1 == 0) r1 = c;
                else if (r2 == 0) begin r2 = c; rd2a = rd_addr[0]; end
            end
            if (resp_valid[0]) begin
                if (rs1 == 0) begin rs1 = c; rfe1 = rf_en[0]; end
                else if (rs2 == 0) begin rs2 = c; rfe2 = rf_en[0]; rfa2 = rf_addr[0]; rfd2 = rf_data[0]; end
            end
            if (c <= 3 && req_ready[0]) busy = 1'b1;
        end
        chk("hold first_rd_cycle",  32'(r1),  32'd1);
        chk("hold rd0_resp_cycle",  32'(rs1), 32'd3);
        chk("hold rd0_rf_en",       32'(rfe1), 32'd0);
        chk("hold ready_low_busy",  32'(busy), 32'd0);
        chk("hold second_rd_cycle", 32'(r2),  32'd5);
        chk("hold second_rd_addr",  rd2a,     32'h0000_0080);
        chk("hold second_resp",     32'(rs2), 32'd7);
        chk("hold second_rf_en",    32'(rfe2), 32'd1);
        chk("hold second_rf_addr",  32'(rfa2), 32'd6);
        chk("hold second_rf_data",  rfd2,     32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
